ie_stage_hs: RTL and testbench

//  Handshaked, parametrised RV32I execute stage between decode (ID) and memory (MEM) stages.
//  - Selects operands with forwarding, runs the ALU and resolves branches/jumps.
//  - Registers result, store data, rd, redirect target and flags in one output pipeline register.
//  - Valid/ready on both sides, stall and flush support; optional multi-cycle multiply.

---
 rtl/ie_pkg.sv | 52 +++++
 rtl/ie_seq_mult.sv | 54 +++++
 rtl/ie_stage_hs.sv | 230 +++++++++++++++++++++++
 tb/tb_ie_stage_hs.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ie_pkg.sv
// Shared types for the RV32I execute stage: ALU opcodes, branch kinds,
// forwarding selects and the multiply sequencing FSM states.
// The MUL/DONE states only exist when IE_MUL_EN is defined.
package ie_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  // JAL and JALR share one kind; i_ctrl_jalr picks the target formula.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JAL  = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    FWD_ID  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

`ifdef IE_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } ie_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0
  } ie_state_e;
`endif

endpackage

// File: rtl/ie_seq_mult.sv
// Radix-2 shift-add multiplier, one partial product per cycle.
// Returns the low DATA_WIDTH bits of a*b. o_done flags the final step;
// o_product is stable from the following cycle until the next start.
// Only instantiated when IE_MUL_EN is defined.
module ie_seq_mult
  import ie_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_abort,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;

  // Load operands on start, then add/shift once per cycle until the count runs out.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_abort) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (i_start) begin
      acc_q    <= '0;
      mcand_q  <= i_a;
      mplier_q <= i_b;
      cnt_q    <= CNT_W'(DATA_WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = busy_q && (cnt_q == CNT_W'(1));
  assign o_product = acc_q;

endmodule

// File: rtl/ie_stage_hs.sv
// Handshaked RV32I execute stage: operand forwarding, ALU, branch resolve,
// one output pipeline register toward MEM. Define IE_MUL_EN to get a
// multi-cycle ALU_MUL; otherwise ALU_MUL is flagged illegal with result 0.
module ie_stage_hs
  import ie_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int REG_FILE_DEPTH = 32,
  parameter  int PC_WIDTH       = 32,
  localparam int REG_FILE_ADDR  = $clog2(REG_FILE_DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_ID_valid,
  output logic                     o_IE_ready,
  input  logic                     i_flush,
  input  logic [ALU_OP_W-1:0]      i_ctrl_alu_op,
  input  logic                     i_ctrl_alu_src,
  input  logic [2:0]               i_ctrl_br_type,
  input  logic                     i_ctrl_jalr,
  input  logic [1:0]               i_fwd_a_sel,
  input  logic [1:0]               i_fwd_b_sel,
  input  logic [DATA_WIDTH-1:0]    i_MEM_fwd_data,
  input  logic [DATA_WIDTH-1:0]    i_WB_fwd_data,
  input  logic [DATA_WIDTH-1:0]    i_ID_read_data_1,
  input  logic [DATA_WIDTH-1:0]    i_ID_read_data_2,
  input  logic [DATA_WIDTH-1:0]    i_ID_immediate,
  input  logic [PC_WIDTH-1:0]      i_ID_program_ctr,
  input  logic [REG_FILE_ADDR-1:0] i_ID_rd_addr,
  output logic                     o_IE_valid,
  input  logic                     i_MEM_ready,
  output logic [DATA_WIDTH-1:0]    o_IE_result,
  output logic [DATA_WIDTH-1:0]    o_IE_data_write,
  output logic [REG_FILE_ADDR-1:0] o_IE_rd_addr,
  output logic [PC_WIDTH-1:0]      o_IE_PC_target,
  output logic                     o_IE_br_taken,
  output logic                     o_ctrl_zero_flag,
  output logic                     o_IE_illegal
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    result;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [REG_FILE_ADDR-1:0] rd;
    logic [PC_WIDTH-1:0]      target;
    logic                     taken;
    logic                     zero;
    logic                     illegal;
  } ie_out_t;

  logic [DATA_WIDTH-1:0] op_a, rs2_fwd, op_b, alu_res, jalr_sum;
  logic [SHAMT_W-1:0]    shamt;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic                  illegal_c, taken_c, out_free, accept;
  logic                  load_single, load_mul;
  ie_out_t               new_c, mul_out, out_q, out_d;
  logic                  valid_q, valid_d;

  // Forwarding muxes; unused select encoding falls back to the register file.
  always_comb begin
    case (i_fwd_a_sel)
      FWD_MEM: op_a = i_MEM_fwd_data;
      FWD_WB:  op_a = i_WB_fwd_data;
      default: op_a = i_ID_read_data_1;
    endcase
    case (i_fwd_b_sel)
      FWD_MEM: rs2_fwd = i_MEM_fwd_data;
      FWD_WB:  rs2_fwd = i_WB_fwd_data;
      default: rs2_fwd = i_ID_read_data_2;
    endcase
    op_b = i_ctrl_alu_src ? i_ID_immediate : rs2_fwd;
  end

  assign shamt = op_b[SHAMT_W-1:0];

  // ALU; unknown opcodes produce 0 and raise the illegal flag.
  always_comb begin
    alu_res   = '0;
    illegal_c = 1'b0;
    case (i_ctrl_alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = DATA_WIDTH'(op_a < op_b);
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
`ifdef IE_MUL_EN
      ALU_MUL:  alu_res = '0;  // real result comes from the multiplier
`else
      ALU_MUL:  illegal_c = 1'b1;
`endif
      default:  illegal_c = 1'b1;
    endcase
  end

  // Branch comparator on the forwarded rs1/rs2 (never the immediate).
  always_comb begin
    case (i_ctrl_br_type)
      BR_BEQ:  taken_c = (op_a == rs2_fwd);
      BR_BNE:  taken_c = (op_a != rs2_fwd);
      BR_BLT:  taken_c = ($signed(op_a) < $signed(rs2_fwd));
      BR_BGE:  taken_c = ($signed(op_a) >= $signed(rs2_fwd));
      BR_BLTU: taken_c = (op_a < rs2_fwd);
      BR_BGEU: taken_c = (op_a >= rs2_fwd);
      BR_JAL:  taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  assign pc_plus4 = i_ID_program_ctr + PC_WIDTH'(4);
  assign jalr_sum = op_a + i_ID_immediate;

  // Everything the output register would capture for a single-cycle op.
  always_comb begin
    new_c         = '0;
    new_c.result  = (i_ctrl_br_type == BR_JAL) ? DATA_WIDTH'(pc_plus4) : alu_res;
    new_c.wdata   = rs2_fwd;
    new_c.rd      = i_ID_rd_addr;
    new_c.target  = i_ctrl_jalr ? (PC_WIDTH'(jalr_sum) & ~PC_WIDTH'(1))
                                : (i_ID_program_ctr + PC_WIDTH'(i_ID_immediate));
    new_c.taken   = taken_c;
    new_c.zero    = (alu_res == '0);
    new_c.illegal = illegal_c;
  end

  assign out_free = !valid_q || i_MEM_ready;
  assign accept   = i_ID_valid && o_IE_ready && !i_flush;

`ifdef IE_MUL_EN
  ie_state_e             state_q, state_d;
  ie_out_t               pend_q;
  logic                  is_mul, mul_start, mul_busy, mul_done;
  logic [DATA_WIDTH-1:0] mul_prod;

  assign is_mul      = (i_ctrl_alu_op == ALU_MUL);
  assign mul_start   = accept && is_mul;
  assign load_single = accept && !is_mul;
  assign load_mul    = (state_q == ST_DONE) && out_free;
  assign o_IE_ready  = (state_q == ST_IDLE) && out_free;

  ie_seq_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_abort   (i_flush),
    .i_start   (mul_start),
    .i_a       (op_a),
    .i_b       (op_b),
    .o_busy    (mul_busy),
    .o_done    (mul_done),
    .o_product (mul_prod)
  );

  // Multiply sequencing; flush aborts back to IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      // Leaving on !busy too keeps the FSM from wedging if the multiplier idles.
      ST_MUL:  if (mul_done || !mul_busy) state_d = ST_DONE;
      ST_DONE: if (out_free) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  // State register plus side fields of the MUL instruction held while it runs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) pend_q <= new_c;
    end
  end

  always_comb begin
    mul_out        = pend_q;
    mul_out.result = mul_prod;
    mul_out.zero   = (mul_prod == '0);
  end
`else
  assign load_single = accept;
  assign load_mul    = 1'b0;
  assign o_IE_ready  = out_free;
  assign mul_out     = '0;
`endif

  // Output register: hold under backpressure, clear on MEM take, flush wins.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (i_MEM_ready) valid_d = 1'b0;
    if (load_single) begin
      out_d   = new_c;
      valid_d = 1'b1;
    end else if (load_mul) begin
      out_d   = mul_out;
      valid_d = 1'b1;
    end
    if (i_flush) valid_d = 1'b0;
  end

  // Output pipeline register toward MEM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign o_IE_valid       = valid_q;
  assign o_IE_result      = out_q.result;
  assign o_IE_data_write  = out_q.wdata;
  assign o_IE_rd_addr     = out_q.rd;
  assign o_IE_PC_target   = out_q.target;
  assign o_IE_br_taken    = out_q.taken;
  assign o_ctrl_zero_flag = out_q.zero;
  assign o_IE_illegal     = out_q.illegal;

endmodule

// File: tb/tb_ie_stage_hs.sv
// Bench for ie_stage_hs: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a cycle-level reference model.
module tb_ie_stage_hs;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLL = 2, OP_SLT = 3, OP_SLTU = 4,
                 OP_XOR = 5, OP_SRL = 6, OP_SRA = 7, OP_OR = 8, OP_AND = 9,
                 OP_MUL = 10;
  localparam int BR_NONE = 0, BR_BEQ = 1, BR_BNE = 2, BR_BLT = 3, BR_BGE = 4,
                 BR_BLTU = 5, BR_BGEU = 6, BR_J = 7;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_ID_valid = 1'b0, i_flush = 1'b0;
  logic        i_MEM_ready = 1'b1;
  logic [3:0]  i_ctrl_alu_op = '0;
  logic        i_ctrl_alu_src = 1'b0, i_ctrl_jalr = 1'b0;
  logic [2:0]  i_ctrl_br_type = '0;
  logic [1:0]  i_fwd_a_sel = '0, i_fwd_b_sel = '0;
  logic [31:0] i_MEM_fwd_data = '0, i_WB_fwd_data = '0;
  logic [31:0] i_ID_read_data_1 = '0, i_ID_read_data_2 = '0, i_ID_immediate = '0;
  logic [31:0] i_ID_program_ctr = '0;
  logic [4:0]  i_ID_rd_addr = '0;
  logic        o_IE_ready, o_IE_valid, o_IE_br_taken, o_ctrl_zero_flag, o_IE_illegal;
  logic [31:0] o_IE_result, o_IE_data_write, o_IE_PC_target;
  logic [4:0]  o_IE_rd_addr;

  ie_stage_hs dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ID_valid(i_ID_valid), .o_IE_ready(o_IE_ready),
    .i_flush(i_flush), .i_ctrl_alu_op(i_ctrl_alu_op), .i_ctrl_alu_src(i_ctrl_alu_src),
    .i_ctrl_br_type(i_ctrl_br_type), .i_ctrl_jalr(i_ctrl_jalr),
    .i_fwd_a_sel(i_fwd_a_sel), .i_fwd_b_sel(i_fwd_b_sel),
    .i_MEM_fwd_data(i_MEM_fwd_data), .i_WB_fwd_data(i_WB_fwd_data),
    .i_ID_read_data_1(i_ID_read_data_1), .i_ID_read_data_2(i_ID_read_data_2),
    .i_ID_immediate(i_ID_immediate), .i_ID_program_ctr(i_ID_program_ctr),
    .i_ID_rd_addr(i_ID_rd_addr), .o_IE_valid(o_IE_valid), .i_MEM_ready(i_MEM_ready),
    .o_IE_result(o_IE_result), .o_IE_data_write(o_IE_data_write),
    .o_IE_rd_addr(o_IE_rd_addr), .o_IE_PC_target(o_IE_PC_target),
    .o_IE_br_taken(o_IE_br_taken), .o_ctrl_zero_flag(o_ctrl_zero_flag),
    .o_IE_illegal(o_IE_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] op; logic src; logic [2:0] br; logic jalr; logic [1:0] fa, fb;
    logic [31:0] rs1, rs2, imm, pc, memd, wbd; logic [4:0] rd;
  } in_t;

  typedef struct {
    logic [31:0] res, wdata, tgt; logic [4:0] rd; logic taken, zero, ill;
  } exp_t;

  typedef struct {
    in_t in; logic [31:0] res, tgt; logic taken, zero, ill;
  } vec_t;

  int n_checks = 0, n_err = 0;
  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input int op, input bit src, input int br, input bit jalr,
                             input int fa, input int fb, input logic [31:0] rs1, rs2,
                             imm, pc, memd, wbd);
    in_t v;
    v.op = 4'(op); v.src = src; v.br = 3'(br); v.jalr = jalr;
    v.fa = 2'(fa); v.fb = 2'(fb); v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.pc = pc; v.memd = memd; v.wbd = wbd; v.rd = 5'd7;
    return v;
  endfunction

  task automatic add_vec(input in_t v, input logic [31:0] res, input logic taken,
                         input logic [31:0] tgt, input logic zero, input logic ill);
    vec_t e;
    e.in = v; e.res = res; e.taken = taken; e.tgt = tgt; e.zero = zero; e.ill = ill;
    vq.push_back(e);
  endtask

  task automatic drive(input in_t v);
    i_ctrl_alu_op = v.op; i_ctrl_alu_src = v.src; i_ctrl_br_type = v.br;
    i_ctrl_jalr = v.jalr; i_fwd_a_sel = v.fa; i_fwd_b_sel = v.fb;
    i_ID_read_data_1 = v.rs1; i_ID_read_data_2 = v.rs2; i_ID_immediate = v.imm;
    i_ID_program_ctr = v.pc; i_MEM_fwd_data = v.memd; i_WB_fwd_data = v.wbd;
    i_ID_rd_addr = v.rd;
  endtask

  // Reference: instruction semantics from the ISA rules, plain arithmetic.
  function automatic exp_t model(input in_t v);
    exp_t e;
    logic [31:0] a, r2, b, alu;
    bit ill;
    a  = (v.fa == 1) ? v.memd : (v.fa == 2) ? v.wbd : v.rs1;
    r2 = (v.fb == 1) ? v.memd : (v.fb == 2) ? v.wbd : v.rs2;
    b  = v.src ? v.imm : r2;
    ill = 0; alu = 0;
    case (int'(v.op))
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_SLL:  alu = a << (b % 32);
      OP_SLT:  alu = (int'(a) < int'(b)) ? 1 : 0;
      OP_SLTU: alu = (a < b) ? 1 : 0;
      OP_XOR:  alu = a ^ b;
      OP_SRL:  alu = a >> (b % 32);
      OP_SRA:  alu = 32'(int'(a) >>> (b % 32));
      OP_OR:   alu = a | b;
      OP_AND:  alu = a & b;
`ifdef IE_MUL_EN
      OP_MUL:  alu = a * b;
`endif
      default: ill = 1;
    endcase
    case (int'(v.br))
      BR_BEQ:  e.taken = (a == r2);
      BR_BNE:  e.taken = (a != r2);
      BR_BLT:  e.taken = (int'(a) < int'(r2));
      BR_BGE:  e.taken = (int'(a) >= int'(r2));
      BR_BLTU: e.taken = (a < r2);
      BR_BGEU: e.taken = (a >= r2);
      BR_J:    e.taken = 1;
      default: e.taken = 0;
    endcase
    e.res   = (v.br == 3'(BR_J)) ? v.pc + 4 : alu;
    e.zero  = (alu == 0);
    e.tgt   = v.jalr ? ((a + v.imm) & 32'hFFFF_FFFE) : v.pc + v.imm;
    e.wdata = r2;
    e.rd    = v.rd;
    e.ill   = ill;
    return e;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},  o_IE_valid, 0);
    chk({tag, "_ready"},  o_IE_ready, 1);
    chk({tag, "_result"}, o_IE_result, 0);
    chk({tag, "_wdata"},  o_IE_data_write, 0);
    chk({tag, "_rd"},     o_IE_rd_addr, 0);
    chk({tag, "_target"}, o_IE_PC_target, 0);
    chk({tag, "_taken"},  o_IE_br_taken, 0);
    chk({tag, "_zero"},   o_ctrl_zero_flag, 0);
    chk({tag, "_illegal"}, o_IE_illegal, 0);
  endtask

  initial begin
    in_t  v;
    exp_t m_out;
    bit   m_valid, m_ready;
    int   cyc, seen;

    // ---- power-on reset ----
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk_reset_state("por");

    // ---- vector table ----
    add_vec(mk(OP_ADD, 1, BR_NONE, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, 32'h40, 0, 0),
            32'h0, 0, 32'h41, 1, 0);
    add_vec(mk(OP_SUB, 0, BR_BLT, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 0),
            32'hFFFF_FFFE, 1, 32'h120, 0, 0);
    add_vec(mk(OP_SUB, 0, BR_BLTU, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 0),
            32'hFFFF_FFFE, 0, 32'h120, 0, 0);
    add_vec(mk(OP_SUB, 0, BR_NONE, 0, 1, 2, 32'hAAAA, 32'hBBBB, 0, 0, 32'h10, 32'h3),
            32'hD, 0, 32'h0, 0, 0);
    add_vec(mk(OP_SLL, 1, BR_NONE, 0, 0, 0, 1, 0, 33, 32'h200, 0, 0),
            32'h2, 0, 32'h221, 0, 0);
    add_vec(mk(OP_SRA, 0, BR_NONE, 0, 0, 0, 32'h8000_0000, 4, 0, 0, 0, 0),
            32'hF800_0000, 0, 32'h0, 0, 0);
    add_vec(mk(OP_ADD, 1, BR_J, 1, 0, 0, 32'h1001, 0, 32'h10, 32'h300, 0, 0),
            32'h304, 1, 32'h1010, 0, 0);
    add_vec(mk(OP_XOR, 0, BR_BEQ, 0, 0, 0, 32'h1234, 32'h1234, 32'hFFFF_FFF8, 32'h10, 0, 0),
            32'h0, 1, 32'h8, 1, 0);
    add_vec(mk(15, 0, BR_NONE, 0, 0, 0, 5, 5, 0, 0, 0, 0),
            32'h0, 0, 32'h0, 1, 1);
`ifndef IE_MUL_EN
    add_vec(mk(OP_MUL, 0, BR_NONE, 0, 0, 0, 7, 6, 0, 0, 0, 0),
            32'h0, 0, 32'h0, 1, 1);
`endif
    foreach (vq[i]) begin
      drive(vq[i].in);
      i_ID_valid = 1'b1; i_MEM_ready = 1'b1;
      @(negedge i_clk);
      i_ID_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_valid", i),  o_IE_valid, 1);
      chk($sformatf("vec%0d_result", i), o_IE_result, vq[i].res);
      chk($sformatf("vec%0d_taken", i),  o_IE_br_taken, vq[i].taken);
      chk($sformatf("vec%0d_target", i), o_IE_PC_target, vq[i].tgt);
      chk($sformatf("vec%0d_zero", i),   o_ctrl_zero_flag, vq[i].zero);
      chk($sformatf("vec%0d_illegal", i), o_IE_illegal, vq[i].ill);
    end
    @(negedge i_clk);  // drain

    // ---- backpressure: hold for 3 cycles, then one per cycle ----
    drive(mk(OP_ADD, 1, BR_NONE, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    i_ID_valid = 1'b1; i_MEM_ready = 1'b0;
    @(negedge i_clk);
    drive(mk(OP_ADD, 1, BR_NONE, 0, 0, 0, 3, 0, 4, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k),  o_IE_ready, 0);
      chk($sformatf("bp%0d_valid", k),  o_IE_valid, 1);
      chk($sformatf("bp%0d_result", k), o_IE_result, 2);
      @(negedge i_clk);
    end
    i_MEM_ready = 1'b1;
    #1 chk("bp_release_ready", o_IE_ready, 1);
    @(negedge i_clk);
    chk("bp_b_result", o_IE_result, 7);
    chk("bp_b_valid",  o_IE_valid, 1);
    drive(mk(OP_ADD, 1, BR_NONE, 0, 0, 0, 10, 0, 5, 0, 0, 0));
    @(negedge i_clk);
    chk("bp_c_result", o_IE_result, 15);
    chk("bp_c_valid",  o_IE_valid, 1);
    i_ID_valid = 1'b0;
    @(negedge i_clk);
    chk("bp_drained", o_IE_valid, 0);

    // ---- flush beats a same-cycle accept ----
    drive(mk(OP_ADD, 1, BR_NONE, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    i_ID_valid = 1'b1; i_flush = 1'b1;
    @(negedge i_clk);
    i_ID_valid = 1'b0; i_flush = 1'b0;
    chk("flush_accept_valid", o_IE_valid, 0);

`ifdef IE_MUL_EN
    // ---- multiply latency ----
    drive(mk(OP_MUL, 0, BR_NONE, 0, 0, 0, 7, 6, 0, 0, 0, 0));
    i_ID_valid = 1'b1;
    @(posedge i_clk);
    #1 i_ID_valid = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge i_clk); cyc++; #1;
      if (cyc == 5) chk("mul_busy_ready", o_IE_ready, 0);
      if (o_IE_valid) break;
    end
    chk("mul_latency", cyc, 33);
    chk("mul_result", o_IE_result, 42);
    chk("mul_illegal", o_IE_illegal, 0);
    @(negedge i_clk);

    // ---- flush mid-multiply ----
    i_ID_valid = 1'b1;
    @(posedge i_clk);
    #1 i_ID_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1 i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    chk("mul_flush_ready", o_IE_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_IE_valid) seen++;
    end
    chk("mul_flush_no_output", seen, 0);
    @(negedge i_clk);
`endif

    // ---- reset mid-stream ----
    drive(mk(OP_ADD, 1, BR_J, 0, 0, 0, 9, 9, 9, 32'h50, 0, 0));
    i_ID_valid = 1'b1; i_MEM_ready = 1'b0;
    @(negedge i_clk);
    chk("pre_reset_valid", o_IE_valid, 1);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    chk_reset_state("mid");
    i_reset = 1'b0; i_ID_valid = 1'b0; i_MEM_ready = 1'b1;

    // ---- randomized traffic vs. reference model ----
    m_valid = 0;
    m_out = '{default: '0};
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      v.op = 4'($urandom_range(15, 0));
`ifdef IE_MUL_EN
      if (v.op == 4'(OP_MUL)) v.op = 4'(OP_ADD);
`endif
      v.src = 1'($urandom()); v.br = 3'($urandom()); v.jalr = 1'($urandom());
      v.fa = 2'($urandom()); v.fb = 2'($urandom());
      v.rs2 = $urandom();
      v.rs1 = ($urandom_range(3, 0) == 0) ? v.rs2 : $urandom();
      v.imm = ($urandom_range(1, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom();
      v.pc = $urandom(); v.memd = $urandom(); v.wbd = $urandom(); v.rd = 5'($urandom());
      drive(v);
      i_ID_valid  = ($urandom_range(9, 0) < 7);
      i_MEM_ready = ($urandom_range(3, 0) != 0);
      i_flush     = ($urandom_range(19, 0) == 0);
      #1;
      m_ready = !m_valid || i_MEM_ready;
      chk("rnd_ready", o_IE_ready, m_ready);
      chk("rnd_valid", o_IE_valid, m_valid);
      if (m_valid) begin
        chk("rnd_result",  o_IE_result, m_out.res);
        chk("rnd_wdata",   o_IE_data_write, m_out.wdata);
        chk("rnd_rd",      o_IE_rd_addr, m_out.rd);
        chk("rnd_target",  o_IE_PC_target, m_out.tgt);
        chk("rnd_taken",   o_IE_br_taken, m_out.taken);
        chk("rnd_zero",    o_ctrl_zero_flag, m_out.zero);
        chk("rnd_illegal", o_IE_illegal, m_out.ill);
      end
      // state after the coming edge
      if (i_flush) m_valid = 0;
      else if (i_ID_valid && m_ready) begin
        m_valid = 1;
        m_out = model(v);
      end else if (i_MEM_ready) m_valid = 0;
    end
    i_ID_valid = 1'b0; i_flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
